// File: rtl/spi_flash_word_reader_if.sv
// CPU-side fetch handshake for the SPI flash word reader.
// The CPU holds the master modport. The reader holds the slave modport.
interface spi_flash_word_reader_if;
   logic [23:0] addr;
   logic        enable;
   logic [15:0] data;
   logic        data_ready;

   modport master (output addr, enable, input  data, data_ready);
   modport slave  (input  addr, enable, output data, data_ready);
endinterface

// File: rtl/spi_flash_word_reader.sv
// Fetches one 16-bit word from SPI NOR flash using READ (0x03), SPI mode 0.
// The first byte lands in data[15:8]. All pin outputs are registered.
module spi_flash_word_reader #(
   parameter int CLK_DIV        = 1,
   parameter int STARTUP_CYCLES = 10000
) (
   input  logic                    clk,
   input  logic                    reset,
   spi_flash_word_reader_if.slave  bus,
   output logic                    flash_clk,
   output logic                    flash_cs_n,
   output logic                    flash_mosi,
   input  logic                    flash_miso
);
   localparam logic [31:0] DIV      = 32'(CLK_DIV);
   localparam logic [31:0] DIV_M1   = 32'(CLK_DIV - 1);
   localparam logic [31:0] DESEL_M1 = 32'(2 * CLK_DIV - 1);
   localparam logic [31:0] START_M1 = 32'(STARTUP_CYCLES - 1);
   localparam logic [7:0]  CMD_READ = 8'h03;

   typedef enum logic [2:0] {STARTUP, IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE} state_t;

   state_t      state;
   logic [31:0] cnt;
   logic [5:0]  bitn;
   logic [31:0] tx;
   logic [15:0] rx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= STARTUP;
         cnt            <= '0;
         bitn           <= '0;
         tx             <= '0;
         rx             <= '0;
         bus.data       <= '0;
         bus.data_ready <= 1'b0;
         flash_clk      <= 1'b0;
         flash_cs_n     <= 1'b1;
         flash_mosi     <= 1'b0;
      end else begin
         case (state)
            STARTUP: begin
               if (cnt == START_M1) begin
                  cnt            <= '0;
                  bus.data_ready <= 1'b1;
                  state          <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            IDLE: begin
               if (bus.enable) begin
                  tx             <= {CMD_READ, bus.addr};
                  flash_mosi     <= CMD_READ[7];
                  cnt            <= '0;
                  bitn           <= '0;
                  bus.data_ready <= 1'b0;
                  flash_cs_n     <= 1'b0;
                  state          <= CS_SETUP;
               end
            end
            CS_SETUP: begin
               if (cnt == DIV_M1) begin
                  cnt   <= '0;
                  state <= SHIFT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (cnt == DIV_M1) begin
                  cnt <= '0;
                  if (!flash_clk) begin
                     // Rising SCK: MISO has been stable since the previous falling edge.
                     flash_clk <= 1'b1;
                     if (bitn >= 6'd32)
                        rx <= {rx[14:0], flash_miso};
                  end else begin
                     flash_clk <= 1'b0;
                     if (bitn == 6'd47) begin
                        flash_mosi <= 1'b0;
                        state      <= CS_HOLD;
                     end else begin
                        // Shifting in zeros makes MOSI idle at 0 after the address.
                        bitn       <= bitn + 1'b1;
                        flash_mosi <= tx[30];
                        tx         <= {tx[30:0], 1'b0};
                     end
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CS_HOLD: begin
               if (cnt == DIV) begin
                  cnt            <= '0;
                  flash_cs_n     <= 1'b1;
                  bus.data       <= rx;
                  bus.data_ready <= 1'b1;
                  state          <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               // The counter saturates once the minimum deselect time has been met.
               if (cnt < DESEL_M1) begin
                  cnt <= cnt + 1'b1;
               end else if (!bus.enable) begin
                  cnt   <= '0;
                  state <= IDLE;
               end
            end
            default: state <= STARTUP;
         endcase
      end
   end
endmodule
